// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction-fetch and load/store valid/ready handshake bundle
interface mc_ctrl_if #(
  parameter int XLEN = 32
);
  logic            if_req_valid_o;
  logic            if_req_ready_i;
  logic [XLEN-1:0] if_addr_o;
  logic            if_rsp_valid_i;
  logic [31:0]     if_rsp_data_i;
  logic            lsu_req_valid_o;
  logic            lsu_req_ready_i;
  logic            lsu_rsp_valid_i;
  modport master (
    output if_req_valid_o, if_addr_o, lsu_req_valid_o,
    input  if_req_ready_i, if_rsp_valid_i, if_rsp_data_i, lsu_req_ready_i, lsu_rsp_valid_i
  );
  modport slave (
    input  if_req_valid_o, if_addr_o, lsu_req_valid_o,
    output if_req_ready_i, if_rsp_valid_i, if_rsp_data_i, lsu_req_ready_i, lsu_rsp_valid_i
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencer, PC unit, halt/trap state and cycle/retire counters
module mc_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h80000000,
  parameter int              ALIGN_CHECK = 1,
  parameter int              CNT_WIDTH   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mc_ctrl_if.master            bus,
  output logic [31:0]          inst_o,
  input  logic                 dec_jal_i,
  input  logic                 dec_jalr_i,
  input  logic                 dec_branch_i,
  input  logic                 dec_load_i,
  input  logic                 dec_store_i,
  input  logic                 dec_ebreak_i,
  input  logic                 dec_illegal_i,
  input  logic                 dec_wen_i,
  input  logic [4:0]           rd_i,
  input  logic                 br_taken_i,
  input  logic [XLEN-1:0]      rs1_rdata_i,
  input  logic [XLEN-1:0]      imm_i,
  output logic                 rf_wen_o,
  output logic [1:0]           rf_wsel_o,
  output logic [XLEN-1:0]      pc_o,
  output logic                 retire_o,
  output logic                 halted_o,
  output logic                 trap_o,
  output logic [1:0]           trap_cause_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_o
);
  typedef enum logic [2:0] {FETCH, WAIT_I, EXEC, MEM_REQ, MEM_WAIT, HALT, TRAP} state_t;
  state_t               state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d, target, pc_plus4;
  logic [31:0]          inst_q, inst_d;
  logic                 halted_q, halted_d, trap_q, trap_d, retire, rf_wen, wen_ok, misaligned;
  logic [1:0]           cause_q, cause_d, wsel;
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d, instret_q, instret_d;
  // next-PC candidate for the instruction sitting in EXEC
  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    target     = dec_jalr_i ? ((rs1_rdata_i + imm_i) & ~XLEN'(1)) :
                 (dec_jal_i || (dec_branch_i && br_taken_i)) ? pc_q + imm_i : pc_plus4;
    misaligned = (ALIGN_CHECK != 0) && target[1];
    wen_ok     = dec_wen_i && (rd_i != 5'd0);
  end
  // sequencer: state transitions, PC/instruction updates, writeback and retire strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    retire    = 1'b0;
    rf_wen    = 1'b0;
    wsel      = 2'd0;
    case (state_q)
      FETCH:   state_d = bus.if_req_ready_i ? WAIT_I : FETCH;
      WAIT_I:  if (bus.if_rsp_valid_i) begin
        inst_d  = bus.if_rsp_data_i;
        state_d = EXEC;
      end
      EXEC: if (dec_illegal_i) begin
        trap_d  = 1'b1;
        cause_d = 2'd0;
        state_d = TRAP;
      end else if (dec_ebreak_i) begin
        retire   = 1'b1;
        halted_d = 1'b1;
        state_d  = HALT;
      end else if (dec_load_i || dec_store_i) begin
        state_d = MEM_REQ;
      end else if (misaligned) begin
        trap_d  = 1'b1;
        cause_d = 2'd1;
        state_d = TRAP;
      end else begin
        rf_wen  = wen_ok;
        wsel    = (dec_jal_i || dec_jalr_i) ? 2'd2 : 2'd0;
        pc_d    = target;
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEM_REQ: if (bus.lsu_req_ready_i) begin
        retire  = dec_store_i;
        pc_d    = dec_store_i ? pc_plus4 : pc_q;
        state_d = dec_store_i ? FETCH : MEM_WAIT;
      end
      MEM_WAIT: if (bus.lsu_rsp_valid_i) begin
        rf_wen  = wen_ok;
        wsel    = 2'd1;
        retire  = 1'b1;
        pc_d    = pc_plus4;
        state_d = FETCH;
      end
      default: state_d = state_q;
    endcase
    cycle_d   = cycle_q + CNT_WIDTH'(1);
    instret_d = instret_q + CNT_WIDTH'(retire);
  end
  // state registers; reset wins over every state, including mid-handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end
  assign bus.if_req_valid_o  = (state_q == FETCH) && !rst_i;
  assign bus.if_addr_o       = pc_q;
  assign bus.lsu_req_valid_o = (state_q == MEM_REQ) && !rst_i;
  assign rf_wen_o            = rf_wen && !rst_i;
  assign rf_wsel_o           = wsel;
  assign retire_o            = retire && !rst_i;
  assign inst_o              = inst_q;
  assign pc_o                = pc_q;
  assign halted_o            = halted_q;
  assign trap_o              = trap_q;
  assign trap_cause_o        = cause_q;
  assign cycle_cnt_o         = cycle_q;
  assign instret_o           = instret_q;
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencer and PC unit; the successor to the single-cycle datapath's fixed "pc+4 / jal / jalr" next-PC logic and its always-on register write.
- Drives instruction fetch and load/store through valid/ready handshakes with variable-latency memories.
- Resolves conditional branches and gates register-file writes.
- Holds sticky halt (ebreak) and trap (illegal instruction, misaligned target) states, and keeps cycle and retire counters.
- Sits between ifu/mem on the memory side and idu/exu/regfile on the datapath side.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h80000000, PC loaded on reset
ALIGN_CHECK, 1, 1: trap on a jump/branch target with bit 1 set; 0: no check
CNT_WIDTH, 64, width of the cycle and retire counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
if_req_valid_o  out  1  fetch request valid
if_req_ready_i  in  1  fetch request accepted
if_addr_o  out  XLEN  fetch address (equals pc_o)
if_rsp_valid_i  in  1  fetch data valid
if_rsp_data_i  in  32  fetched instruction
inst_o  out  32  latched instruction, feeds idu
dec_jal_i, dec_jalr_i, dec_branch_i, dec_load_i, dec_store_i, dec_ebreak_i, dec_illegal_i, dec_wen_i  in  1 each  decoded class flags from idu
rd_i  in  5  destination register
br_taken_i  in  1  branch comparison result from exu
rs1_rdata_i  in  XLEN  rs1 value
imm_i  in  XLEN  immediate
lsu_req_valid_o  out  1  load/store request valid
lsu_req_ready_i  in  1  load/store request accepted
lsu_rsp_valid_i  in  1  load data valid
rf_wen_o  out  1  regfile write enable
rf_wsel_o  out  2  writeback source: 0 = exu, 1 = mem, 2 = pc+4
pc_o  out  XLEN  current PC
retire_o  out  1  one-cycle pulse per retired instruction
halted_o  out  1  sticky, set by ebreak
trap_o  out  1  sticky trap flag
trap_cause_o  out  2  0 = illegal, 1 = misaligned target
cycle_cnt_o  out  CNT_WIDTH  cycles since reset
instret_o  out  CNT_WIDTH  instructions retired

Behaviour:
- States: FETCH, WAIT_I, EXEC, MEM_REQ, MEM_WAIT, HALT, TRAP.
- Reset (clock edge with rst_i=1):
  - state=FETCH, pc=RESET_PC, inst=0, counters=0, halted=0, trap=0, cause=0.
  - All request, write and pulse outputs are 0 while rst_i=1.
  - Reset overrides every state, including mid-handshake.
- Memories share rst_i; responses to requests issued before reset are the memory side's responsibility and are not filtered here.
- FETCH: if_req_valid_o=1 with if_addr_o=pc, held stable until if_req_ready_i=1, then → WAIT_I. The first request is issued in the cycle after reset deasserts.
- WAIT_I: on if_rsp_valid_i, inst <= if_rsp_data_i and → EXEC. if_rsp_valid_i in any other state is ignored.
- EXEC (exactly one cycle; decode and exu are combinational from inst_o). Priority, highest first:
  1. illegal → TRAP, cause=0.
  2. ebreak → retire, → HALT.
  3. load or store → MEM_REQ.
  4. otherwise compute the target:
     - jalr: (rs1+imm) & ~1
     - jal, or branch with br_taken_i: pc+imm
     - else: pc+4
     - If ALIGN_CHECK and target[1]=1 → TRAP, cause=1, no write, pc unchanged.
     - Else rf_wen_o = dec_wen_i && rd_i≠0, with rf_wsel_o = 2 for jal/jalr and 0 otherwise; pc <= target; retire; → FETCH.
- MEM_REQ: lsu_req_valid_o=1 until lsu_req_ready_i.
  - On handshake, store: retire, pc <= pc+4, → FETCH.
  - On handshake, load: → MEM_WAIT.
- MEM_WAIT: on lsu_rsp_valid_i: rf_wen_o = dec_wen_i && rd_i≠0, rf_wsel_o=1, retire, pc <= pc+4, → FETCH.
- HALT and TRAP are absorbing until reset:
  - No requests, no writes.
  - pc_o holds the ebreak or faulting PC.
  - halted_o or trap_o held at 1.
- retire_o is a single-cycle pulse in the retiring cycle. instret increments on the same edge.
- cycle_cnt_o increments every non-reset cycle, including in HALT and TRAP.
- Both counters wrap modulo 2^CNT_WIDTH.
- PC arithmetic is modulo 2^XLEN; no overflow detection.
- rf_wen_o is combinational from state and inputs, and is 0 in all other states.

Test Plan:
- Reset, then 0-wait memory: addi x1,x0,5 at 0x80000000 → if_addr_o=0x80000000; rf_wen_o=1 and retire_o=1 in cycle 3 (EXEC); next fetch at 0x80000004.
- if_req_ready_i low 3 cycles, rsp 2 cycles after accept → if_addr_o stable throughout; no retire until data arrives; inst_o = fetched word.
- beq taken, imm=-8 at pc 0x80000010 → next fetch 0x80000008. Same with br_taken_i=0 → 0x80000014. rf_wen_o=0 in both cases.
- jalr with rs1=0x80000101, imm=0 → target 0x80000100, rf_wsel_o=2. Then rs1=0x80000102 → trap_o=1, cause=1, pc_o unchanged, no rf write.
- lw with lsu_rsp delayed 4 cycles, and rd=x0 → lsu_req_valid_o held until ready; rf_wen_o=0; retire on rsp; instret +1.
- ebreak → halted_o=1, no further if_req_valid_o, cycle_cnt_o keeps counting. Assert rst_i during MEM_WAIT → pc=0x80000000, FETCH, counters 0.
